wb_rr_arbiter: RTL
==================

# wb_rr_arbiter

Round-robin Wishbone B4 classic arbiter sharing the single SoC slave port (the `wb_m2s_*` / `wb_s2m_*` port of the SoC top) between `NUM_MASTERS` bus masters, e.g. the test/UVC master, a boot loader and a DMA engine. A master keeps ownership for as long as it holds `cyc`, so multi-access sequences to the SPI, UART and I2C register files are never interleaved. The block sits between the masters and the SoC top in the hardware top. An optional watchdog aborts accesses the slave never acknowledges.

## Interface
- `NUM_MASTERS`, default 2: number of requesters; legal range 2..8.
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; select width is `DATA_W/8`.
- `TIMEOUT`, default 255: watchdog limit in cycles; legal range 1..65535. Used only with `WB_ARB_TIMEOUT_EN`.

Ports:
- `wb_clk`  in  1  clock; all state changes on the rising edge.
- `wb_rst`  in  1  reset, asynchronous and active-high.
- `m_cyc`  in  `NUM_MASTERS`  per-master cycle request.
- `m_stb`  in  `NUM_MASTERS`  per-master strobe.
- `m_we`  in  `NUM_MASTERS`  per-master write enable.
- `m_adr`  in  `NUM_MASTERS*ADDR_W`  packed addresses; master i occupies `[i*ADDR_W +: ADDR_W]`.
- `m_dat_w`  in  `NUM_MASTERS*DATA_W`  packed write data.
- `m_sel`  in  `NUM_MASTERS*DATA_W/8`  packed byte selects.
- `m_dat_r`  out  `DATA_W`  read data, broadcast to all masters.
- `m_ack`  out  `NUM_MASTERS`  per-master acknowledge.
- `m_err`  out  `NUM_MASTERS`  per-master error; driven 0 without the macro.
- `s_cyc`, `s_stb`, `s_we`  out  1 each  to the slave.
- `s_adr`  out  `ADDR_W`;  `s_dat_w`  out  `DATA_W`;  `s_sel`  out  `DATA_W/8`.
- `s_dat_r`  in  `DATA_W`;  `s_ack`  in  1  from the slave.
- `grant`  out  `NUM_MASTERS`  one-hot current owner; all zeros when no master owns the bus.

## Operation
- **State machine states:** IDLE, OWN, and ABORT (ABORT exists only with the macro).
- **Reset values:** state = IDLE, `grant` = 0, round-robin pointer = 0, watchdog counter = 0. All `s_*` outputs and `m_ack`/`m_err` are 0. `s_adr`, `s_dat_w` and `s_sel` are 0 while `grant` = 0.
- **Arbitration (from IDLE):**
  - If any `m_cyc` bit is high, register a one-hot grant to the first requester searching upward (with wrap) from the pointer. Move to OWN.
  - The pointer becomes (winner+1) mod `NUM_MASTERS`.
- **OWN:**
  - `s_*` is driven combinationally from the granted master's inputs.
  - `m_ack[g] = s_ack`; all other `m_ack` bits are 0. `m_dat_r = s_dat_r` at all times.
- **Release:**
  - When `m_cyc[g]` is low in OWN, the grant is recomputed on that edge from the current requesters using the updated pointer. The result is OWN with the new master, or IDLE if nobody requests.
  - There are no dead cycles between owners.
- **Locking:** a master that holds `cyc` keeps the bus indefinitely. Fairness applies only at release.
- **Non-granted masters:** see `m_ack` = 0 and simply wait.
- **Simultaneous events:** if `m_cyc[g]` falls in the same cycle that `s_ack` arrives, the ack is still passed through to master g.

## Timing
- **Grant latency:** one cycle from `m_cyc` rising (bus idle) to `grant`/`s_cyc` asserted.
- **Owner data path:** zero cycles. Addresses, data and ack pass through combinationally once granted.
- **Handover:** owner A drops `cyc` at edge N; owner B sees `s_cyc` driven from its inputs in cycle N+1.
- **Reset mid-transfer:** outputs clear immediately and asynchronously. A master's stb is dropped without an ack.

## Configuration
- **`WB_ARB_TIMEOUT_EN` defined:**
  - A 16-bit watchdog counts cycles in OWN while `s_stb` is high and `s_ack` is low. It clears on `s_ack` or on a change of owner.
  - When the count reaches `TIMEOUT`, `m_err[g]` pulses high for one cycle and the state moves to ABORT.
  - ABORT drives `s_cyc`/`s_stb` to 0 and holds `grant`. When the master drops `cyc`, normal release arbitration follows.
- **Not defined:** there is no counter and no ABORT state, `m_err` is tied to 0, and a hung slave hangs its owner forever.

## Test plan
- **Reset values:** assert `wb_rst` mid-cycle with master 0 active → all outputs 0 on the same edge, `grant` = 0, and the first grant after release goes to master 0.
- **Single master write:** master 1 writes 0x5A to 0x0000_0104 → `grant` = 2'b10 one cycle later, `s_adr`/`s_dat_w` match, and `m_ack[1]` is high exactly in the cycle `s_ack` is high.
- **Simultaneous requests:** both masters raise `cyc` in the same cycle from reset → master 0 is served first; master 1 is granted the cycle after master 0 drops `cyc`.
- **Round-robin fairness:** both masters request continuously with 1-access bursts → grants alternate 0,1,0,1 with no idle cycles.
- **Locking:** master 0 holds `cyc` across 4 accesses while master 1 requests → master 1 receives no ack until master 0 releases.
- **Watchdog (`WB_ARB_TIMEOUT_EN`, `TIMEOUT`=8):** slave never acks → `m_err` pulses in the cycle the count reaches 8 and `s_cyc` falls. After the master drops `cyc`, the pending master 1 is granted.

Source files
------------

// File: rtl/wb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// wb_rr_arbiter
//
// Round-robin Wishbone B4 classic arbiter that shares one slave port between
// NUM_MASTERS bus masters. The winning master keeps the bus for as long as it
// holds cyc, so multi-access register sequences are never interleaved.
// Fairness is applied only when the owner releases cyc.
//
// Optional feature macro: WB_ARB_TIMEOUT_EN
//   When defined, a 16-bit watchdog aborts an access the slave never
//   acknowledges. After TIMEOUT stalled strobe cycles, m_err pulses to the
//   owner and the slave cycle is dropped until the owner releases cyc.
//   When undefined, m_err is tied low and there is no ABORT state.
//
// Parameters:
//   NUM_MASTERS  number of requesters (2..8)
//   ADDR_W       address width
//   DATA_W       data width (select width is DATA_W/8)
//   TIMEOUT      watchdog limit in cycles (1..65535), used with the macro
//
// Ports:
//   wb_clk, wb_rst          clock, asynchronous active-high reset
//   m_cyc/m_stb/m_we        per-master control, one bit per master
//   m_adr/m_dat_w/m_sel     packed per-master address, write data, selects
//   m_dat_r                 slave read data broadcast to every master
//   m_ack/m_err             per-master acknowledge / error
//   s_cyc/s_stb/s_we        control towards the slave
//   s_adr/s_dat_w/s_sel     address, write data, selects towards the slave
//   s_dat_r/s_ack           read data and acknowledge from the slave
//   grant                   one-hot current owner, zero when the bus is idle
// -----------------------------------------------------------------------------
module wb_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                            wb_clk,
  input  logic                            wb_rst,
  input  logic [NUM_MASTERS-1:0]          m_cyc,
  input  logic [NUM_MASTERS-1:0]          m_stb,
  input  logic [NUM_MASTERS-1:0]          m_we,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_adr,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_dat_w,
  input  logic [NUM_MASTERS*(DATA_W/8)-1:0] m_sel,
  output logic [DATA_W-1:0]               m_dat_r,
  output logic [NUM_MASTERS-1:0]          m_ack,
  output logic [NUM_MASTERS-1:0]          m_err,
  output logic                            s_cyc,
  output logic                            s_stb,
  output logic                            s_we,
  output logic [ADDR_W-1:0]               s_adr,
  output logic [DATA_W-1:0]               s_dat_w,
  output logic [DATA_W/8-1:0]             s_sel,
  input  logic [DATA_W-1:0]               s_dat_r,
  input  logic                            s_ack,
  output logic [NUM_MASTERS-1:0]          grant
);

  localparam int SEL_W = DATA_W / 8;
  localparam int PTR_W = $clog2(NUM_MASTERS);

  // Catch illegal configurations at elaboration time.
  if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_num_masters
    $error("wb_rr_arbiter: NUM_MASTERS must be in 2..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("wb_rr_arbiter: TIMEOUT must be in 1..65535");
  end

`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, OWN, ABORT} state_t;
`else
  typedef enum logic [0:0] {IDLE, OWN} state_t;
`endif

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;

  logic                   arb_found;
  logic [NUM_MASTERS-1:0] arb_oh;
  logic [PTR_W-1:0]       arb_next_ptr;

  logic                   own_cyc, own_stb, own_we;
  logic [ADDR_W-1:0]      own_adr;
  logic [DATA_W-1:0]      own_dat;
  logic [SEL_W-1:0]       own_sel;
  logic                   bus_live;
  logic                   do_arb;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] WDOG_LIMIT = 16'(TIMEOUT);
  logic [15:0] wdog_q, wdog_d;
  logic        err_q, err_d;
`endif

  // Round-robin search: first requester at or above the pointer, wrapping.
  // The pointer already holds (last winner + 1), so this one search serves
  // both the idle case and the release case.
  always_comb begin
    int k;
    k            = 0;
    arb_found    = 1'b0;
    arb_oh       = '0;
    arb_next_ptr = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      k = int'(ptr_q) + i;
      if (k >= NUM_MASTERS) k = k - NUM_MASTERS;
      if (!arb_found && m_cyc[k]) begin
        arb_found    = 1'b1;
        arb_oh[k]    = 1'b1;
        arb_next_ptr = (k == NUM_MASTERS - 1) ? '0 : PTR_W'(k + 1);
      end
    end
  end

  // AND-OR mux of the owner's inputs; a zero grant naturally yields zeros,
  // which keeps the slave-side address/data/select quiet when idle.
  always_comb begin
    own_cyc = |(m_cyc & grant);
    own_stb = |(m_stb & grant);
    own_we  = |(m_we  & grant);
    own_adr = '0;
    own_dat = '0;
    own_sel = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      own_adr = own_adr | (m_adr[i*ADDR_W +: ADDR_W]   & {ADDR_W{grant[i]}});
      own_dat = own_dat | (m_dat_w[i*DATA_W +: DATA_W] & {DATA_W{grant[i]}});
      own_sel = own_sel | (m_sel[i*SEL_W +: SEL_W]     & {SEL_W{grant[i]}});
    end
  end

  // Slave-side outputs. Cycle and strobe only pass while the owner is live;
  // during an abort the grant is held but the slave sees no cycle.
  always_comb begin
    bus_live = (state_q == OWN);
    s_cyc    = bus_live & own_cyc;
    s_stb    = bus_live & own_stb;
    s_we     = own_we;
    s_adr    = own_adr;
    s_dat_w  = own_dat;
    s_sel    = own_sel;
    m_dat_r  = s_dat_r;
    m_ack    = grant & {NUM_MASTERS{bus_live & s_ack}};
`ifdef WB_ARB_TIMEOUT_EN
    m_err    = grant & {NUM_MASTERS{err_q}};
`else
    m_err    = '0;
`endif
  end

  // Next-state logic. Arbitration runs from IDLE, or whenever the current
  // owner has dropped cyc, so a waiting master takes over on the same edge
  // with no dead cycle in between.
  always_comb begin
    state_d = state_q;
    grant_d = grant;
    ptr_d   = ptr_q;
    do_arb  = 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
    wdog_d  = wdog_q;
    err_d   = 1'b0;
`endif

    case (state_q)
      IDLE: do_arb = 1'b1;
      OWN: begin
        if (!own_cyc) begin
          do_arb = 1'b1;
        end
`ifdef WB_ARB_TIMEOUT_EN
        else if (s_ack) begin
          wdog_d = '0;
        end else if (own_stb) begin
          if (wdog_q == WDOG_LIMIT - 16'd1) begin
            wdog_d  = WDOG_LIMIT;
            err_d   = 1'b1;
            state_d = ABORT;
          end else begin
            wdog_d = wdog_q + 16'd1;
          end
        end
`endif
      end
`ifdef WB_ARB_TIMEOUT_EN
      ABORT: begin
        if (!own_cyc) do_arb = 1'b1;
      end
`endif
      default: do_arb = 1'b1;
    endcase

    if (do_arb) begin
`ifdef WB_ARB_TIMEOUT_EN
      wdog_d = '0;
`endif
      if (arb_found) begin
        state_d = OWN;
        grant_d = arb_oh;
        ptr_d   = arb_next_ptr;
      end else begin
        state_d = IDLE;
        grant_d = '0;
      end
    end
  end

  // State register; reset clears ownership at once, which drops every
  // combinational slave-side and ack output in the same instant.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state_q <= IDLE;
      grant   <= '0;
      ptr_q   <= '0;
`ifdef WB_ARB_TIMEOUT_EN
      wdog_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant   <= grant_d;
      ptr_q   <= ptr_d;
`ifdef WB_ARB_TIMEOUT_EN
      wdog_q  <= wdog_d;
      err_q   <= err_d;
`endif
    end
  end

endmodule
